// File: rtl/nonce_uart_framer.sv
// nonce_uart_framer: queues 32-bit nonce words in a small FIFO and streams each
// word as four bytes into a UART transmitter core using a start/busy handshake.
module nonce_uart_framer #(
    parameter int FIFO_DEPTH = 4,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int ACK_WAIT   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] word_in,
    input  logic        word_valid,
    output logic        word_full,
    output logic [7:0]  tx_byte,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        overflow,
    output logic        idle
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int AW = (ACK_WAIT > 1) ? $clog2(ACK_WAIT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    // Word FIFO
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          push, pop;

    // Transmit FSM
    state_t        state_q, state_d;
    logic [31:0]   nonce_q, nonce_d;
    logic [2:0]    byte_cnt_q, byte_cnt_d;
    logic [AW-1:0] wait_q, wait_d;
    logic [7:0]    tx_byte_q, tx_byte_d;

    // Byte lane for transmit position idx (0 = first byte on the wire).
    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [1:0] lane;
        lane = MSB_FIRST ? ~idx : idx;
        return w[{lane, 3'b000} +: 8];
    endfunction

    // Fullness is judged on the pre-pop occupancy, so a push while full is dropped
    // even when LOAD frees a slot in the same cycle.
    assign word_full = (count_q == CW'(FIFO_DEPTH));
    assign push      = word_valid && !word_full;
    assign pop       = (state_q == LOAD);
    assign idle      = (state_q == IDLE) && (count_q == '0);
    assign overflow  = overflow_q;
    assign tx_byte   = tx_byte_q;

    // FIFO pointer, occupancy and sticky overflow next-state.
    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        overflow_d = overflow_q | (word_valid & word_full);
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage write port.
    // NOTE: the storage array has no reset; pointers and count alone say which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= word_in;
        end
    end

    // FSM next-state, byte selection and start pulse.
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        nonce_d    = nonce_q;
        byte_cnt_d = byte_cnt_q;
        wait_d     = wait_q;
        tx_byte_d  = tx_byte_q;
        tx_start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                nonce_d    = mem_q[rd_ptr_q];
                byte_cnt_d = 3'd0;
                tx_byte_d  = pick_byte(mem_q[rd_ptr_q], 2'd0);
                state_d    = START;
            end
            START: begin
                tx_start = 1'b1;
                wait_d   = '0;
                state_d  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // A core that never acknowledges must not stall the stream.
                if (tx_busy || (wait_q == AW'(ACK_WAIT - 1))) begin
                    state_d = WAIT_DONE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_d < 3'd4) begin
                        tx_byte_d = pick_byte(nonce_q, byte_cnt_d[1:0]);
                        state_d   = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset discards the current word and everything queued.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            nonce_q    <= '0;
            byte_cnt_q <= '0;
            wait_q     <= '0;
            tx_byte_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            nonce_q    <= nonce_d;
            byte_cnt_q <= byte_cnt_d;
            wait_q     <= wait_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

endmodule

// File: tb/tb_nonce_uart_framer.sv
// Bench for nonce_uart_framer: byte scoreboard fed at push time, drained by a
// tx_start monitor, with a simple transmitter-core model on tx_busy.
module tb_nonce_uart_framer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // MSB-first instance
    logic [31:0] word_in;
    logic        word_valid, word_full, tx_start, tx_busy, overflow, idle;
    logic [7:0]  tx_byte;

    // LSB-first instance
    logic [31:0] word_in_l;
    logic        word_valid_l, word_full_l, tx_start_l, tx_busy_l, overflow_l, idle_l;
    logic [7:0]  tx_byte_l;

    int checks = 0;
    int errors = 0;
    int starts = 0;
    int starts_l = 0;
    bit never_busy = 1'b0;
    int bcnt, bcnt_l;
    logic [7:0] exp_q[$];
    logic [7:0] exp_l[$];
    logic [7:0] mon_e, mon_el;

    nonce_uart_framer #(.FIFO_DEPTH(4), .MSB_FIRST(1'b1), .ACK_WAIT(3)) dut (
        .clk(clk), .reset(reset), .word_in(word_in), .word_valid(word_valid),
        .word_full(word_full), .tx_byte(tx_byte), .tx_start(tx_start),
        .tx_busy(tx_busy), .overflow(overflow), .idle(idle)
    );

    nonce_uart_framer #(.FIFO_DEPTH(4), .MSB_FIRST(1'b0), .ACK_WAIT(3)) dut_lsb (
        .clk(clk), .reset(reset), .word_in(word_in_l), .word_valid(word_valid_l),
        .word_full(word_full_l), .tx_byte(tx_byte_l), .tx_start(tx_start_l),
        .tx_busy(tx_busy_l), .overflow(overflow_l), .idle(idle_l)
    );

    // Transmitter-core models: busy for 10 cycles after each start (unless never_busy).
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_busy <= 1'b0;
            bcnt    <= 0;
        end else if (tx_start && !never_busy) begin
            tx_busy <= 1'b1;
            bcnt    <= 10;
        end else if (bcnt > 0) begin
            bcnt <= bcnt - 1;
            if (bcnt == 1) tx_busy <= 1'b0;
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_busy_l <= 1'b0;
            bcnt_l    <= 0;
        end else if (tx_start_l) begin
            tx_busy_l <= 1'b1;
            bcnt_l    <= 10;
        end else if (bcnt_l > 0) begin
            bcnt_l <= bcnt_l - 1;
            if (bcnt_l == 1) tx_busy_l <= 1'b0;
        end
    end

    // Scoreboard monitors: every start pulse must match the next expected byte.
    always @(negedge clk) begin
        if (!reset && tx_start) begin
            starts++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL msb_unexpected_byte got=%h expected=none", tx_byte);
            end else begin
                mon_e = exp_q.pop_front();
                if (tx_byte !== mon_e) begin
                    errors++;
                    $display("FAIL msb_byte got=%h expected=%h", tx_byte, mon_e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && tx_start_l) begin
            starts_l++;
            checks++;
            if (exp_l.size() == 0) begin
                errors++;
                $display("FAIL lsb_unexpected_byte got=%h expected=none", tx_byte_l);
            end else begin
                mon_el = exp_l.pop_front();
                if (tx_byte_l !== mon_el) begin
                    errors++;
                    $display("FAIL lsb_byte got=%h expected=%h", tx_byte_l, mon_el);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1);
    end

    task automatic push_msb(input logic [31:0] w, input bit expect_tx);
        word_in    = w;
        word_valid = 1'b1;
        @(negedge clk);
        word_valid = 1'b0;
        if (expect_tx) for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
    endtask

    task automatic push_lsb(input logic [31:0] w);
        word_in_l    = w;
        word_valid_l = 1'b1;
        @(negedge clk);
        word_valid_l = 1'b0;
        for (int i = 0; i < 4; i++) exp_l.push_back(w[8*i +: 8]);
    endtask

    task automatic wait_drain(input bit lsb, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (lsb ? (exp_l.size() == 0 && idle_l) : (exp_q.size() == 0 && idle)) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_drain got=left_%0d expected=0", name, lsb ? exp_l.size() : exp_q.size());
        end
    endtask

    task automatic wait_start(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_start) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_start got=none expected=pulse", name);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx_byte got=%h expected=00", tx_byte); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got=%b expected=0", tx_start); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b expected=0", overflow); end
        checks++; if (word_full !== 1'b0) begin errors++; $display("FAIL reset_word_full got=%b expected=0", word_full); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got=%b expected=1", idle); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_latency();
        int s0 = starts;
        word_in    = 32'hDEAD_BEEF;
        word_valid = 1'b1;
        for (int i = 3; i >= 0; i--) exp_q.push_back(word_in[8*i +: 8]);
        @(negedge clk);
        word_valid = 1'b0;
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL latency_n1 got=%b expected=0", tx_start); end
        @(negedge clk);
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL latency_n2 got=%b expected=0", tx_start); end
        @(negedge clk);
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL latency_n3 got=%b expected=1", tx_start); end
        @(negedge clk);
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL latency_pulse_width got=%b expected=0", tx_start); end
        wait_drain(1'b0, "latency");
        repeat (20) @(negedge clk);
        checks++; if (starts - s0 !== 4) begin errors++; $display("FAIL latency_count got=%0d expected=4", starts - s0); end
    endtask

    task automatic test_lsb_first();
        push_lsb(32'h0102_0304);
        wait_drain(1'b1, "lsb");
        repeat (5) @(negedge clk);
        checks++; if (starts_l !== 4) begin errors++; $display("FAIL lsb_count got=%0d expected=4", starts_l); end
    endtask

    task automatic test_overflow();
        int s0 = starts;
        push_msb(32'hA5A5_0001, 1'b1);
        wait_start("ovf_pre");
        push_msb(32'h1111_2222, 1'b1);
        push_msb(32'h3333_4444, 1'b1);
        push_msb(32'h5555_6666, 1'b1);
        push_msb(32'h7777_8888, 1'b1);
        checks++; if (word_full !== 1'b1) begin errors++; $display("FAIL ovf_full got=%b expected=1", word_full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b expected=0", overflow); end
        push_msb(32'h9999_AAAA, 1'b0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b expected=1", overflow); end
        wait_drain(1'b0, "ovf");
        repeat (10) @(negedge clk);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b expected=1", overflow); end
        checks++; if (starts - s0 !== 20) begin errors++; $display("FAIL ovf_count got=%0d expected=20", starts - s0); end
    endtask

    task automatic test_push_on_pop();
        bit cleared = 1'b0;
        int s0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pop_ovf_cleared got=%b expected=0", overflow); end
        s0 = starts;
        push_msb(32'hC0DE_0001, 1'b1);
        wait_start("pop_pre");
        push_msb(32'hC0DE_0002, 1'b1);
        push_msb(32'hC0DE_0003, 1'b1);
        push_msb(32'hC0DE_0004, 1'b1);
        push_msb(32'hC0DE_0005, 1'b1);
        checks++; if (word_full !== 1'b1) begin errors++; $display("FAIL pop_full got=%b expected=1", word_full); end
        // Keep pushing a word that must never be sent until LOAD frees a slot.
        word_in    = 32'hBAD0_BAD0;
        word_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!word_full) begin
                cleared = 1'b1;
                break;
            end
        end
        word_valid = 1'b0;
        checks++; if (!cleared) begin errors++; $display("FAIL pop_slot got=full expected=not_full"); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL pop_ovf got=%b expected=1", overflow); end
        push_msb(32'hC0DE_0006, 1'b1);
        checks++; if (word_full !== 1'b1) begin errors++; $display("FAIL pop_count got=%b expected=1", word_full); end
        wait_drain(1'b0, "pop");
        repeat (10) @(negedge clk);
        checks++; if (starts - s0 !== 24) begin errors++; $display("FAIL pop_total got=%0d expected=24", starts - s0); end
    endtask

    task automatic test_no_busy();
        int last = -1;
        int s0 = starts;
        never_busy = 1'b1;
        push_msb(32'h1234_5678, 1'b1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_start) begin
                if (last >= 0) begin
                    checks++;
                    if (i - last !== 5) begin errors++; $display("FAIL nobusy_gap got=%0d expected=5", i - last); end
                end
                last = i;
            end
        end
        checks++; if (starts - s0 !== 4) begin errors++; $display("FAIL nobusy_count got=%0d expected=4", starts - s0); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL nobusy_idle got=%b expected=1", idle); end
        never_busy = 1'b0;
    endtask

    task automatic test_reset_mid_word();
        int s1;
        push_msb(32'hDDCC_BBAA, 1'b1);
        wait_start("mid_b1");
        push_msb(32'h0BAD_0001, 1'b1);
        push_msb(32'h0BAD_0002, 1'b1);
        wait_start("mid_b2");
        reset = 1'b1;
        #1;
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL mid_start got=%b expected=0", tx_start); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL mid_idle_in_reset got=%b expected=1", idle); end
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        s1 = starts;
        repeat (100) @(negedge clk);
        checks++; if (starts !== s1) begin errors++; $display("FAIL mid_no_tx got=%0d expected=%0d", starts, s1); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL mid_idle got=%b expected=1", idle); end
    endtask

    initial begin
        reset        = 1'b1;
        word_in      = '0;
        word_valid   = 1'b0;
        word_in_l    = '0;
        word_valid_l = 1'b0;
        test_reset();
        test_latency();
        test_lsb_first();
        test_overflow();
        test_push_on_pop();
        test_no_busy();
        test_reset_mid_word();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
